// File: rtl/data_memory_unit_if.sv
// Request/response bus between the memory-stage control and the data memory unit.
// The master drives requests; the slave (the memory) returns ready/done/fault/data.
interface data_memory_unit_if #(
    parameter int n = 64
);
    logic [n-1:0] input_address;
    logic [n-1:0] input_write_data;
    logic         input_mem_read;
    logic         input_mem_write;
    logic         input_valid;
    logic         output_ready;
    logic [n-1:0] output_read_data;
    logic         output_done;
    logic         output_fault;

    modport master (
        output input_address, input_write_data, input_mem_read, input_mem_write, input_valid,
        input  output_ready, output_read_data, output_done, output_fault
    );

    modport slave (
        input  input_address, input_write_data, input_mem_read, input_mem_write, input_valid,
        output output_ready, output_read_data, output_done, output_fault
    );
endinterface

// File: rtl/data_memory_unit.sv
// Multi-cycle LEGv8 doubleword data memory: IDLE -> BUSY (LATENCY cycles) -> RESP.
// Loads/stores use the ALU result as a byte address; faults are reported with done.
module data_memory_unit #(
    parameter int n       = 64,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input logic               clk,
    input logic               reset,
    data_memory_unit_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [AW-1:0]  idx_q;
    logic [n-1:0]   wdata_q;
    logic           write_q;
    logic           fault_q;
    logic           ready_q;
    logic           done_q;
    logic           fault_out_q;
    logic [n-1:0]   rdata_q;

    // Entries never written since reset read as zero, so reset clears the whole
    // array through this flag vector instead of touching every data word.
    logic [DEPTH-1:0] entry_written;
    logic [n-1:0]     mem [DEPTH];

    logic req_any;
    logic req_fault;
    logic commit_store;

    assign req_any   = bus.input_valid && (bus.input_mem_read || bus.input_mem_write);
    assign req_fault = (bus.input_mem_read && bus.input_mem_write)
                     || (|bus.input_address[2:0])
                     || (|bus.input_address[n-1:AW+3]);

    assign commit_store = (state == BUSY) && (cnt == '0) && write_q && !fault_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            idx_q         <= '0;
            wdata_q       <= '0;
            write_q       <= 1'b0;
            fault_q       <= 1'b0;
            ready_q       <= 1'b1;
            done_q        <= 1'b0;
            fault_out_q   <= 1'b0;
            rdata_q       <= '0;
            entry_written <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_any) begin
                        state   <= BUSY;
                        cnt     <= CW'(LATENCY - 1);
                        idx_q   <= bus.input_address[AW+2:3];
                        wdata_q <= bus.input_write_data;
                        write_q <= bus.input_mem_write;
                        fault_q <= req_fault;
                        ready_q <= 1'b0;
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        state       <= RESP;
                        done_q      <= 1'b1;
                        fault_out_q <= fault_q;
                        if (fault_q) begin
                            rdata_q <= '0;
                        end else if (write_q) begin
                            entry_written[idx_q] <= 1'b1;
                        end else begin
                            rdata_q <= entry_written[idx_q] ? mem[idx_q] : '0;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    state       <= IDLE;
                    done_q      <= 1'b0;
                    fault_out_q <= 1'b0;
                    ready_q     <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && commit_store) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign bus.output_ready     = ready_q;
    assign bus.output_done      = done_q;
    assign bus.output_fault     = fault_out_q;
    assign bus.output_read_data = rdata_q;
endmodule

// File: tb/tb_data_memory_unit.sv
// Directed bench for data_memory_unit with a response scoreboard.
// Instance a uses LATENCY=2, instance b uses LATENCY=1.
module tb_data_memory_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_a;
    logic reset_b;

    data_memory_unit_if #(.n(64)) ifa ();
    data_memory_unit_if #(.n(64)) ifb ();

    data_memory_unit #(.n(64), .DEPTH(256), .LATENCY(2)) dut_a (
        .clk  (clk),
        .reset(reset_a),
        .bus  (ifa.slave)
    );

    data_memory_unit #(.n(64), .DEPTH(256), .LATENCY(1)) dut_b (
        .clk  (clk),
        .reset(reset_b),
        .bus  (ifb.slave)
    );

    int checks = 0;
    int errors = 0;

    logic [63:0] model [2][256];
    logic [63:0] held  [2];

    typedef struct packed {
        logic        fault;
        logic [63:0] data;
    } exp_t;

    exp_t sb [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int s, input logic v, input logic rd, input logic wr,
                         input logic [63:0] addr, input logic [63:0] wd);
        if (s == 0) begin
            ifa.input_valid      = v;
            ifa.input_mem_read   = rd;
            ifa.input_mem_write  = wr;
            ifa.input_address    = addr;
            ifa.input_write_data = wd;
        end else begin
            ifb.input_valid      = v;
            ifb.input_mem_read   = rd;
            ifb.input_mem_write  = wr;
            ifb.input_address    = addr;
            ifb.input_write_data = wd;
        end
    endtask

    function automatic logic get_ready(input int s);
        return (s == 0) ? ifa.output_ready : ifb.output_ready;
    endfunction

    function automatic logic get_done(input int s);
        return (s == 0) ? ifa.output_done : ifb.output_done;
    endfunction

    function automatic logic get_fault(input int s);
        return (s == 0) ? ifa.output_fault : ifb.output_fault;
    endfunction

    function automatic logic [63:0] get_rdata(input int s);
        return (s == 0) ? ifa.output_read_data : ifb.output_read_data;
    endfunction

    task automatic clear_model(input int s);
        for (int i = 0; i < 256; i++) model[s][i] = 64'h0;
        held[s] = 64'h0;
    endtask

    // Reference behaviour: compute the response the request must produce and queue it.
    task automatic expect_push(input int s, input logic rd, input logic wr,
                               input logic [63:0] addr, input logic [63:0] wd);
        exp_t e;
        logic [7:0] ix;
        ix = addr[10:3];
        e.fault = (rd && wr) || (addr[2:0] != 3'b000) || (addr >= 64'h800);
        if (e.fault)   held[s] = 64'h0;
        else if (wr)   model[s][ix] = wd;
        else           held[s] = model[s][ix];
        e.data = held[s];
        sb.push_back(e);
    endtask

    // Called on the first negedge after acceptance; returns cycles until done.
    task automatic wait_done(input int s, input string tag, output int k, output int low);
        exp_t e;
        bit   got;
        got = 1'b0;
        k   = 1;
        low = 0;
        while (!got && k <= 20) begin
            if (!get_ready(s)) low++;
            if (get_done(s)) got = 1'b1;
            else begin
                @(negedge clk);
                k++;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $error("FAIL %s_timeout observed=no_done expected=done", tag);
            if (sb.size() > 0) void'(sb.pop_front());
        end else if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_unexpected observed=done expected=no_done", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_fault"}, {63'h0, get_fault(s)}, {63'h0, e.fault});
            chk({tag, "_data"}, get_rdata(s), e.data);
            chk({tag, "_rdy_excl"}, {63'h0, get_ready(s)}, 64'h0);
        end
    endtask

    task automatic access(input int s, input logic rd, input logic wr,
                          input logic [63:0] addr, input logic [63:0] wd, input string tag);
        int k;
        int low;
        int lat;
        lat = (s == 0) ? 2 : 1;
        @(negedge clk);
        chk({tag, "_ready"}, {63'h0, get_ready(s)}, 64'h1);
        expect_push(s, rd, wr, addr, wd);
        drive(s, 1'b1, rd, wr, addr, wd);
        @(negedge clk);
        drive(s, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
        wait_done(s, tag, k, low);
        chk({tag, "_lat"}, 64'(k), 64'(lat + 1));
        chk({tag, "_low"}, 64'(low), 64'(lat + 1));
    endtask

    initial begin
        int k;
        int low;

        drive(0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
        drive(1, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
        clear_model(0);
        clear_model(1);
        reset_a = 1'b1;
        reset_b = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_a = 1'b0;
        reset_b = 1'b0;

        // Reset state
        chk("rst_ready", {63'h0, ifa.output_ready}, 64'h1);
        chk("rst_done",  {63'h0, ifa.output_done},  64'h0);
        chk("rst_fault", {63'h0, ifa.output_fault}, 64'h0);
        chk("rst_rdata", ifa.output_read_data,      64'h0);
        access(0, 1'b1, 1'b0, 64'h10, 64'h0, "rst_load");

        // Store then load
        access(0, 1'b0, 1'b1, 64'h18, 64'hDEADBEEF_CAFEF00D, "store18");
        access(0, 1'b1, 1'b0, 64'h18, 64'h0, "load18");

        // Faults (held data is nonzero going in, so zeroing is visible)
        access(0, 1'b1, 1'b0, 64'h1C, 64'h0, "misalign");
        access(0, 1'b1, 1'b0, 64'h18, 64'h0, "reload18");
        access(0, 1'b1, 1'b0, 64'h800, 64'h0, "oor");
        access(0, 1'b1, 1'b1, 64'h20, 64'h77, "both");
        access(0, 1'b0, 1'b1, 64'h800, 64'hFFFF_FFFF_FFFF_FFFF, "store_oor");
        for (int i = 0; i < 256; i++) access(0, 1'b1, 1'b0, 64'(i * 8), 64'h0, "sweep");

        // Ignored requests while busy
        access(0, 1'b0, 1'b1, 64'h20, 64'h5555_0000_AAAA_1111, "store20");
        @(negedge clk);
        chk("ign_ready", {63'h0, ifa.output_ready}, 64'h1);
        expect_push(0, 1'b1, 1'b0, 64'h18, 64'h0);
        drive(0, 1'b1, 1'b1, 1'b0, 64'h18, 64'h0);
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 1'b0, 64'h20, 64'h0);
        wait_done(0, "ign1", k, low);
        chk("ign1_lat", 64'(k), 64'd3);
        @(negedge clk);
        chk("ign_ready_back", {63'h0, ifa.output_ready}, 64'h1);
        chk("ign_done_once",  {63'h0, ifa.output_done},  64'h0);
        expect_push(0, 1'b1, 1'b0, 64'h20, 64'h0);
        @(negedge clk);
        chk("ign_accepted", {63'h0, ifa.output_ready}, 64'h0);
        drive(0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
        wait_done(0, "ign2", k, low);
        chk("ign2_lat", 64'(k), 64'd3);

        // Valid with neither read nor write
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 1'b0, 64'h18, 64'h0);
        repeat (4) begin
            @(negedge clk);
            chk("noop_ready", {63'h0, ifa.output_ready}, 64'h1);
            chk("noop_done",  {63'h0, ifa.output_done},  64'h0);
        end
        drive(0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0);

        // Reset during the first BUSY cycle of a store
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 1'b1, 64'h8, 64'h1234);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
        reset_a = 1'b1;
        @(negedge clk);
        reset_a = 1'b0;
        clear_model(0);
        repeat (4) begin
            chk("abort_done",  {63'h0, ifa.output_done},  64'h0);
            chk("abort_ready", {63'h0, ifa.output_ready}, 64'h1);
            @(negedge clk);
        end
        access(0, 1'b1, 1'b0, 64'h8,  64'h0, "abort_load8");
        access(0, 1'b1, 1'b0, 64'h18, 64'h0, "abort_load18");

        // Minimum latency and boundary entries
        access(1, 1'b0, 1'b1, 64'h0,   64'h0BAD_F00D_0000_0001, "b_store0");
        access(1, 1'b0, 1'b1, 64'h7F8, 64'hA5A5_5A5A_0123_4567, "b_top_store");
        access(1, 1'b1, 1'b0, 64'h7F8, 64'h0, "b_top_load");
        access(1, 1'b1, 1'b0, 64'h0,   64'h0, "b_entry0");

        chk("sb_empty", 64'(sb.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
